pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised, elastic pipeline-stage register. It replaces the fixed CE-gated stage latches (IF/ID .. MEM/WB).
//  Carries inst, PC and a generic payload bus between stages using a valid/ready handshake.
//  A 2-entry skid buffer gives full throughput with a registered in_ready.
//  Flush squashes the stage to a NOP bubble. All stages of the RV32i core instantiate this block.
// PARAMETERS
//  XLEN      32             width of inst and PC fields
//  DATA_W    72             payload width (MEM/WB: ALU_out32+data_in32+data_to_reg2+reg_write1+written_reg5)
//  NOP_INST  32'h00000013   instruction presented while the stage holds a bubble (addi x0,x0,0)
//  CNT_W     32             perf counter width (only with PIPE_STAGE_PERF_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  flush        in   1       squash stage contents (branch/exception), synchronous
//  in_valid     in   1       upstream has a valid instruction
//  in_ready     out  1       stage can accept; registered, = ~skid_valid
//  in_inst      in   XLEN    instruction word
//  in_pc        in   XLEN    PC of instruction
//  in_payload   in   DATA_W  control/data bundle
//  out_valid    out  1       stage holds a valid instruction
//  out_ready    in   1       downstream accepts
//  out_inst     out  XLEN    NOP_INST when !out_valid
//  out_pc       out  XLEN    0 when !out_valid
//  out_payload  out  DATA_W  0 when !out_valid (so reg_write-type bits are inert)
//  stall_cnt    out  CNT_W   [PIPE_STAGE_PERF_EN only] cycles with out_valid & !out_ready
//  bubble_cnt   out  CNT_W   [PIPE_STAGE_PERF_EN only] cycles with !out_valid
// BEHAVIOUR
//  - Regs: main{valid,inst,pc,payload} drives outputs; skid{valid,inst,pc,payload} holds overflow.
//  - Reset (rst=1 at edge): main/skid valid=0, out_inst=NOP_INST, out_pc=0, out_payload=0, in_ready=1, counters=0.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency in->out is 1 cycle.
//  - main empty or out_fire: main <= skid if skid_valid (skid_valid<=0), else main <= in (if in_fire), else bubble.
//  - main full & !out_ready & in_fire: word goes to skid, skid_valid<=1 -> in_ready=0 next cycle.
//  - skid_valid=1 and in_ready=0: no input is sampled. Upstream must hold in_* stable while in_valid & !in_ready.
//  - The skid entry always drains into main before any new input. Order is strictly preserved.
//  - Throughput: 1 word/cycle when out_ready=1. Never drops or duplicates a word.
//  - Simultaneous skid drain and in_fire cannot occur (in_ready=0 while skid full).
//  - flush=1 at edge: both valids<=0, main fields <= bubble. in_fire in the same cycle is discarded (flush wins).
//    in_ready=1 next cycle. out_fire in a flush cycle still counts as delivered downstream.
//  - rst has priority over flush; flush has priority over handshake.
//  - Bubble outputs are registered values, never combinational muxes of valid.
// CONFIGURATION
//  PIPE_STAGE_PERF_EN defined:
//    - stall_cnt and bubble_cnt ports exist and increment per cycle as defined above.
//    - Both saturate at all-ones and are cleared by rst only; flush does not clear them.
//  PIPE_STAGE_PERF_EN undefined: ports and counters are absent; zero area cost.
// STRUCTURE
//  - Shared package rv32i_pkg: XLEN, NOP_INST (32'h00000013), MEM_WB payload field offsets/widths
//    (ALU_out, data_in, data_to_reg, reg_write, written_reg), and data_to_reg encodings.
//  - One sub-module: pipe_stage_slot. It is a single valid+inst+pc+payload register with load/clear,
//    instantiated twice (main, skid).
//  - Control (in_ready, load selects, counters) lives in the top module.
// TESTING
//  - Reset: assert rst 2 cycles mid-traffic -> out_valid=0, out_inst=32'h13, out_pc=0, out_payload=0, in_ready=1.
//  - Streaming: out_ready=1, send PC 0x0,0x4,0x8 back to back -> out_pc follows 1 cycle later, no gaps.
//  - Backpressure: out_ready=0 after PC 0x4 accepted, offer 0x8 -> 0x8 in skid, in_ready=0.
//    Release -> 0x4 then 0x8 then 0xC in order, none lost.
//  - Flush: skid full (0x10,0x14), in_valid with 0x18 and flush=1 -> next cycle out_valid=0, out_inst=32'h13,
//    in_ready=1. 0x10/0x14/0x18 never appear.
//  - Flush vs rst: rst=1 & flush=1 same cycle -> reset values; counters (PERF_EN) are zero.
//  - PERF_EN: hold out_ready=0 with valid word 5 cycles -> stall_cnt=5. Idle 3 cycles -> bubble_cnt=3.
//    Force CNT_W=4, run 20 stalls -> saturates at 4'hF.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants: instruction/PC width, bubble instruction, MEM/WB payload layout.
package rv32i_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // MEM/WB payload layout, LSB first
  localparam int WRITTEN_REG_LSB = 0;
  localparam int WRITTEN_REG_W   = 5;
  localparam int REG_WRITE_LSB   = 5;
  localparam int REG_WRITE_W     = 1;
  localparam int DATA_TO_REG_LSB = 6;
  localparam int DATA_TO_REG_W   = 2;
  localparam int DATA_IN_LSB     = 8;
  localparam int DATA_IN_W       = 32;
  localparam int ALU_OUT_LSB     = 40;
  localparam int ALU_OUT_W       = 32;
  localparam int MEM_WB_W        = 72;

  typedef enum logic [1:0] {
    DTR_ALU = 2'd0,
    DTR_MEM = 2'd1,
    DTR_PC4 = 2'd2,
    DTR_IMM = 2'd3
  } data_to_reg_e;

  typedef struct packed {
    logic [ALU_OUT_W-1:0]     alu_out;
    logic [DATA_IN_W-1:0]     data_in;
    data_to_reg_e             data_to_reg;
    logic                     reg_write;
    logic [WRITTEN_REG_W-1:0] written_reg;
  } mem_wb_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One valid+inst+pc+payload register; clear forces a bubble (NOP, zero PC/payload) and wins over load.
// Latency: 1 cycle from load to outputs.
// Backpressure: none inside the slot; the parent decides when to load or clear.
module pipe_stage_slot #(
  parameter int               XLEN     = rv32i_pkg::XLEN,
  parameter int               DATA_W   = rv32i_pkg::MEM_WB_W,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(rv32i_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [XLEN-1:0]   ld_inst,
  input  logic [XLEN-1:0]   ld_pc,
  input  logic [DATA_W-1:0] ld_payload,
  output logic              valid,
  output logic [XLEN-1:0]   inst,
  output logic [XLEN-1:0]   pc,
  output logic [DATA_W-1:0] payload
);

  logic              valid_d, valid_q;
  logic [XLEN-1:0]   inst_d, inst_q;
  logic [XLEN-1:0]   pc_d, pc_q;
  logic [DATA_W-1:0] payload_d, payload_q;

  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    payload_d = payload_q;
    if (clr) begin
      valid_d   = 1'b0;
      inst_d    = NOP_INST;
      pc_d      = '0;
      payload_d = '0;
    end else if (load) begin
      valid_d   = 1'b1;
      inst_d    = ld_inst;
      pc_d      = ld_pc;
      payload_d = ld_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      pc_q      <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      payload_q <= payload_d;
    end
  end

  assign valid   = valid_q;
  assign inst    = inst_q;
  assign pc      = pc_q;
  assign payload = payload_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage (main + skid slot), flush to NOP bubble; PIPE_STAGE_PERF_EN adds stall/bubble counters.
// Latency: 1 cycle in->out, 1 word/cycle sustained while out_ready=1.
// Backpressure: in_ready is registered (= !skid valid); a full skid blocks input until it drains into main.
module pipe_stage_reg #(
  parameter int               XLEN     = rv32i_pkg::XLEN,
  parameter int               DATA_W   = rv32i_pkg::MEM_WB_W,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(rv32i_pkg::NOP_INST)
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int               CNT_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic [DATA_W-1:0] out_payload
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              skid_valid;
  logic [XLEN-1:0]   skid_inst, skid_pc;
  logic [DATA_W-1:0] skid_payload;

  logic              in_fire, main_adv;
  logic              main_load, main_clr, skid_load, skid_clr;
  logic [XLEN-1:0]   main_ld_inst, main_ld_pc;
  logic [DATA_W-1:0] main_ld_payload;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign main_adv = ~out_valid | out_ready;

  // Skid always refills main before new input; the two never coincide since in_ready=0 while skid is full.
  always_comb begin
    main_load       = main_adv & (skid_valid | in_fire);
    main_clr        = flush | (main_adv & ~main_load);
    skid_load       = ~main_adv & in_fire;
    skid_clr        = flush | (main_adv & skid_valid);
    main_ld_inst    = in_inst;
    main_ld_pc      = in_pc;
    main_ld_payload = in_payload;
    if (skid_valid) begin
      main_ld_inst    = skid_inst;
      main_ld_pc      = skid_pc;
      main_ld_payload = skid_payload;
    end
  end

  pipe_stage_slot #(.XLEN(XLEN), .DATA_W(DATA_W), .NOP_INST(NOP_INST)) u_main (
    .clk        (clk),
    .rst        (rst),
    .clr        (main_clr),
    .load       (main_load),
    .ld_inst    (main_ld_inst),
    .ld_pc      (main_ld_pc),
    .ld_payload (main_ld_payload),
    .valid      (out_valid),
    .inst       (out_inst),
    .pc         (out_pc),
    .payload    (out_payload)
  );

  pipe_stage_slot #(.XLEN(XLEN), .DATA_W(DATA_W), .NOP_INST(NOP_INST)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clr        (skid_clr),
    .load       (skid_load),
    .ld_inst    (in_inst),
    .ld_pc      (in_pc),
    .ld_payload (in_payload),
    .valid      (skid_valid),
    .inst       (skid_inst),
    .pc         (skid_pc),
    .payload    (skid_payload)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  // Saturating; only rst clears them so flushes stay visible in the counts.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (!out_valid && (bubble_cnt_q != '1))             bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int CW = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [71:0] pl;
  } word_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_inst, in_pc, out_inst, out_pc;
  logic [71:0] in_payload, out_payload;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  word_t mq[$];
  int    exp_stall = 0;
  int    exp_bubble = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .XLEN(32), .DATA_W(72), .NOP_INST(32'h0000_0013)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_payload (out_payload)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt  (stall_cnt)
    , .bubble_cnt (bubble_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] mkpl(input logic [31:0] pc);
    return {8'hC3, pc, ~pc};
  endfunction

  // Reference: the stage is an ordered queue of at most two words; the head is what downstream sees.
  always @(posedge clk) begin
    int  n;
    bit  rdy;
    word_t w;
    n   = mq.size();
    rdy = (n < 2);
    if (rst) begin
      mq.delete();
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      if (n > 0 && !out_ready && exp_stall < (1 << CW) - 1) exp_stall++;
      if (n == 0 && exp_bubble < (1 << CW) - 1) exp_bubble++;
      if (flush) begin
        mq.delete();
      end else begin
        if (n > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) begin
          w.inst = in_inst;
          w.pc   = in_pc;
          w.pl   = in_payload;
          mq.push_back(w);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (mq.size() > 0) begin
        chk("out_valid", out_valid, 1'b1);
        chk("out_inst", out_inst, mq[0].inst);
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_payload", out_payload, mq[0].pl);
      end else begin
        chk("out_valid", out_valid, 1'b0);
        chk("bubble_inst", out_inst, 32'h13);
        chk("bubble_pc", out_pc, 32'h0);
        chk("bubble_payload", out_payload, 72'h0);
      end
      chk("in_ready", in_ready, mq.size() < 2);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", stall_cnt, exp_stall);
      chk("bubble_cnt", bubble_cnt, exp_bubble);
`endif
    end
  end

  task automatic cyc(input bit v, input logic [31:0] pc, input bit ordy, input bit fl, input bit r);
    in_valid   = v;
    in_pc      = pc;
    in_inst    = {pc[15:0], 16'h0093};
    in_payload = mkpl(pc);
    out_ready  = ordy;
    flush      = fl;
    rst        = r;
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input bit v, input logic [31:0] pc, input bit rdy);
    chk({nm, "_valid"}, out_valid, v);
    chk({nm, "_pc"}, out_pc, v ? pc : 32'h0);
    chk({nm, "_inst"}, out_inst, v ? {pc[15:0], 16'h0093} : 32'h13);
    chk({nm, "_payload"}, out_payload, v ? mkpl(pc) : 72'h0);
    chk({nm, "_in_ready"}, in_ready, rdy);
  endtask

  initial begin
    bit          rdy_at_drive;
    logic [31:0] next_pc;

    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk_on = 1'b1;
    chk_out("reset", 0, 0, 1);

    // streaming, then rst for 2 cycles mid-traffic
    cyc(1, 32'h0, 1, 0, 0); chk_out("stream0", 1, 32'h0, 1);
    cyc(1, 32'h4, 1, 0, 0); chk_out("stream4", 1, 32'h4, 1);
    cyc(1, 32'h8, 1, 0, 0); chk_out("stream8", 1, 32'h8, 1);
    cyc(1, 32'hC, 1, 0, 1);
    cyc(1, 32'h10, 1, 0, 1); chk_out("mid_rst", 0, 0, 1);

    // backpressure through the skid entry
    cyc(1, 32'h4, 1, 0, 0); chk_out("bp_a", 1, 32'h4, 1);
    cyc(1, 32'h8, 0, 0, 0); chk_out("bp_skid", 1, 32'h4, 0);
    cyc(1, 32'hC, 0, 0, 0); chk_out("bp_hold", 1, 32'h4, 0);
    cyc(1, 32'hC, 1, 0, 0); chk_out("bp_drain", 1, 32'h8, 1);
    cyc(1, 32'hC, 1, 0, 0); chk_out("bp_next", 1, 32'hC, 1);
    cyc(0, 32'h0, 1, 0, 0); chk_out("bp_idle", 0, 0, 1);

    // flush with both slots full and a word offered
    cyc(1, 32'h10, 0, 0, 0); chk_out("fl_a", 1, 32'h10, 1);
    cyc(1, 32'h14, 0, 0, 0); chk_out("fl_full", 1, 32'h10, 0);
    cyc(1, 32'h18, 0, 1, 0); chk_out("flush", 0, 0, 1);
    cyc(0, 32'h0, 1, 0, 0); chk_out("fl_after", 0, 0, 1);

    // rst and flush together
    cyc(1, 32'h20, 0, 0, 0);
    cyc(1, 32'h24, 0, 0, 0);
    cyc(1, 32'h28, 1, 1, 1); chk_out("rst_flush", 0, 0, 1);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_flush_stall", stall_cnt, 4'h0);
    chk("rst_flush_bubble", bubble_cnt, 4'h0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("perf_bubble3", bubble_cnt, 4'd3);
    cyc(1, 32'h40, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    chk("perf_stall5", stall_cnt, 4'd5);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
    chk("perf_stall_sat", stall_cnt, 4'hF);
    cyc(0, 0, 1, 1, 0);
    chk("perf_flush_keeps", stall_cnt, 4'hF);
    cyc(0, 0, 1, 1, 1);
    chk("perf_rst_stall", stall_cnt, 4'h0);
    chk("perf_rst_bubble", bubble_cnt, 4'h0);
`endif

    // randomized traffic; an offered word is held until accepted
    next_pc = 32'h100;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rdy_at_drive = in_ready;
      if (!(in_valid && !rdy_at_drive)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          in_pc      = next_pc;
          in_inst    = $urandom;
          in_payload = {$urandom, $urandom, 8'($urandom)};
          next_pc    = next_pc + 32'd4;
        end
      end
      out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 300) == 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
